// File: rtl/imc_wb_initiator.sv
// Single-outstanding Wishbone initiator: host command in, bus cycle out,
// one response back, with an ack timeout and a saturating timeout counter.
module imc_wb_initiator #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ADDR_MASK = 32'h0000_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] wishbone_address_bus,
   output logic [31:0] wishbone_data_out,
   input  logic [31:0] wishbone_data_in,
   output logic        wbs_we_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   input  logic        wbs_ack_i,
   output logic [7:0]  err_count
);

   typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;

   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [9:0]  cnt_q, cnt_d;
   logic [7:0]  errc_q, errc_d;
   logic        in_bus;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      errc_d  = errc_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               we_d    = cmd_we;
               addr_d  = cmd_addr & ADDR_MASK;
               data_d  = cmd_data;
               cnt_d   = '0;
               state_d = BUS;
            end
         end
         BUS: begin
            // ack wins over a timeout landing in the same cycle
            if (wbs_ack_i) begin
               rdata_d = we_q ? '0 : wishbone_data_in;
               err_d   = 1'b0;
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 10'd1;
               if (cnt_q == CNT_LAST) begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = RSP;
                  if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
               end
            end
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         errc_q  <= errc_d;
      end
   end

   assign in_bus               = (state_q == BUS);
   assign cmd_ready            = (state_q == IDLE);
   assign rsp_valid            = (state_q == RSP);
   assign rsp_data             = rdata_q;
   assign rsp_err              = err_q;
   assign wbs_cyc_o            = in_bus;
   assign wbs_stb_o            = in_bus;
   assign wbs_we_o             = in_bus & we_q;
   assign wishbone_address_bus = in_bus ? addr_q : '0;
   assign wishbone_data_out    = in_bus ? data_q : '0;
   assign err_count            = errc_q;

endmodule

// File: doc/imc_wb_initiator.md
IMC_WB_INITIATOR -- requirements
Module: imc_wb_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum wait cycles for wbs_ack_i before aborting a transaction (range 1..1023).
REQ-002 The block SHALL have parameter ADDR_MASK, default 32'h0000_FFFF, meaning the address bits forwarded onto the bus; all other bits are driven 0.
REQ-003 The block SHALL have port `clk`, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port `cmd_valid`, input, 1 bit: the host offers a command.
REQ-006 The block SHALL have port `cmd_ready`, output, 1 bit: the block accepts the command.
REQ-007 The block SHALL have port `cmd_we`, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port `cmd_addr`, input, 32 bits: the target address.
REQ-009 The block SHALL have port `cmd_data`, input, 32 bits: the write data.
REQ-010 The block SHALL have port `rsp_valid`, output, 1 bit: a response is available.
REQ-011 The block SHALL have port `rsp_ready`, input, 1 bit: the host consumes the response.
REQ-012 The block SHALL have port `rsp_data`, output, 32 bits: read data (0 for writes and errors).
REQ-013 The block SHALL have port `rsp_err`, output, 1 bit: the transaction timed out.
REQ-014 The block SHALL have port `wishbone_address_bus`, output, 32 bits: the bus address.
REQ-015 The block SHALL have port `wishbone_data_out`, output, 32 bits: write data to the target.
REQ-016 The block SHALL have port `wishbone_data_in`, input, 32 bits: read data from the target.
REQ-017 The block SHALL have ports `wbs_we_o`, `wbs_cyc_o` and `wbs_stb_o`, outputs, 1 bit each: bus write-enable, cycle and strobe.
REQ-018 The block SHALL have port `wbs_ack_i`, input, 1 bit: target acknowledge.
REQ-019 The block SHALL have port `err_count`, output, 8 bits: saturating count of timeouts.

Function
REQ-020 The block SHALL implement FSM states IDLE, BUS, RSP.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready at a rising clk edge.
REQ-022 On acceptance the block SHALL latch we, (addr & ADDR_MASK) and data, and enter BUS on the next cycle.
REQ-023 In BUS, wbs_cyc_o = wbs_stb_o = 1 and the address, data and we outputs SHALL be held stable until exit.
REQ-024 In BUS, a 10-bit wait counter SHALL start at 0 and increment each cycle that wbs_ack_i = 0.
REQ-025 wbs_ack_i = 1 in BUS SHALL capture wishbone_data_in (reads only; writes capture 0), set rsp_err = 0, and go to RSP; cyc and stb deassert on the following cycle.
REQ-026 If the counter reaches TIMEOUT without ack, the block SHALL go to RSP with rsp_data = 0, rsp_err = 1, and increment err_count, saturating at 255.
REQ-027 An ack arriving in the same cycle the counter reaches TIMEOUT SHALL count as success, not timeout.
REQ-028 wbs_ack_i outside BUS SHALL be ignored.
REQ-029 In RSP, rsp_valid SHALL be 1, with rsp_data and rsp_err held stable.
REQ-030 rsp_valid & rsp_ready SHALL return the FSM to IDLE; the earliest next acceptance is the cycle after.
REQ-031 Minimum latency SHALL be 3 cycles: accept edge -> BUS with ack in the first BUS cycle -> rsp_valid in the next cycle.
REQ-032 Outside BUS, wishbone_address_bus, wishbone_data_out and wbs_we_o SHALL be driven 0.

Reset
REQ-033 While rst = 0, asynchronously: FSM = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_err = 0; all bus outputs = 0; counter = 0; err_count = 0.
REQ-034 Reset asserted mid-transaction SHALL drop wbs_cyc_o and wbs_stb_o immediately and discard the pending command and response.
REQ-035 After rst rises, the first command SHALL be accepted at the first rising edge with cmd_valid = 1.

Verification
REQ-036 Write 0xDEAD_BEEF to 0x1234_0010, ack after 2 cycles -> bus address 0x0000_0010, we = 1, data 0xDEADBEEF; rsp_valid with rsp_data = 0, rsp_err = 0.
REQ-037 Read 0x0000_0004, target returns 0x0000_000A with ack in the first BUS cycle -> rsp_data = 0x0000_000A exactly 3 cycles after acceptance.
REQ-038 Read with no ack, TIMEOUT = 4 -> rsp_err = 1, rsp_data = 0, err_count = 1; cyc drops after the 4th wait cycle.
REQ-039 Ack coincident with the counter reaching TIMEOUT -> success response, err_count unchanged.
REQ-040 Hold rsp_ready = 0 for 10 cycles with cmd_valid = 1 -> cmd_ready stays 0 and no new bus cycle starts; the response remains stable.
REQ-041 Assert rst in the 2nd BUS cycle -> cyc and stb are 0 in the same cycle, rsp_valid = 0, and a new command is accepted after release.
